// File: rtl/dmem_pkg.sv
// Shared widths and FSM state encoding for the data-memory burst master.
// Leaf package: no timing or flow-control behaviour of its own.
package dmem_pkg;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 10;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RDRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/dmem_rd_slice.sv
// One-entry read output register; a load takes effect on the next edge (1 cycle).
// free is high when empty or draining this cycle; data/last hold while rd_valid & !rd_ready.
module dmem_rd_slice #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              free,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last
);

  assign free = !rd_valid || rd_ready;

  // The owner only raises load while free, so a load never overwrites an unconsumed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
    end else if (load) begin
      rd_valid <= 1'b1;
      rd_data  <= load_data;
      rd_last  <= load_last;
    end else if (rd_valid && rd_ready) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_burst_master.sv
// Burst master on the data-memory port: one write word per cycle, reads reach rd_* one cycle after fetch.
// Write bursts stall on wr_valid; read fetches stall while the output slice is full and rd_ready is low.
module dmem_burst_master
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writedata,
  output logic              memread,
  output logic              memwrite,
  input  logic [DATA_W-1:0] readdata,
  output logic              busy,
  output logic              done
);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  count;
  logic              last_word;
  logic              slice_free;
  logic              load;
  logic              adv;

  assign last_word = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Address wraps modulo 2^ADDR_W; the burst direction lives in the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr <= '0;
      count    <= '0;
    end else if (state == IDLE && cmd_valid) begin
      cur_addr <= cmd_addr;
      count    <= cmd_len;
    end else if (adv) begin
      cur_addr <= cur_addr + ADDR_W'(1);
      count    <= count - LEN_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    memwrite   = 1'b0;
    memread    = 1'b0;
    address    = '0;
    writedata  = '0;
    load       = 1'b0;
    adv        = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          next_state = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        wr_ready  = 1'b1;
        memwrite  = wr_valid;
        writedata = wr_data;
        address   = cur_addr;
        if (wr_valid) begin
          adv = 1'b1;
          if (last_word) begin
            next_state = DONE;
          end
        end
      end
      READ: begin
        memread = 1'b1;
        address = cur_addr;
        if (slice_free) begin
          load = 1'b1;
          adv  = 1'b1;
          if (last_word) begin
            next_state = RDRAIN;
          end
        end
      end
      RDRAIN: begin
        if (rd_valid && rd_ready) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  dmem_rd_slice #(
    .DATA_W(DATA_W)
  ) u_rd_slice (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_data(readdata),
    .load_last(last_word),
    .free     (slice_free),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_last  (rd_last)
  );

endmodule

// File: tb/tb_dmem_burst_master.sv
// Bench for dmem_burst_master: queue-based model of expected memory writes, fetch addresses and read stream.
module tb_dmem_burst_master;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] address;
  logic [DW-1:0] writedata, readdata;
  logic          memread, memwrite, busy, done;

  always #5 clk = ~clk;

  logic [DW-1:0] env_mem [0:1023];
  logic [DW-1:0] ref_mem [0:1023];

  assign readdata = env_mem[address];
  always @(posedge clk) if (memwrite) env_mem[address] <= writedata;

  dmem_burst_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .address(address), .writedata(writedata), .memread(memread), .memwrite(memwrite),
    .readdata(readdata), .busy(busy), .done(done)
  );

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wexp_t;
  typedef struct packed { logic [DW-1:0] d; logic last; } rexp_t;

  wexp_t         exp_wr[$];
  rexp_t         exp_rd[$];
  logic [AW-1:0] exp_fetch[$];

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle compare against the model queues.
  logic          prev_stall = 1'b0;
  logic          prev_last = 1'b0;
  logic          prev_done = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
      prev_done  <= 1'b0;
    end else begin
      chk("rw_exclusive", {31'b0, memread & memwrite}, 32'd0);
      if (memwrite) begin
        if (exp_wr.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          chk("wr_addr", {22'b0, address}, {22'b0, exp_wr[0].a});
          chk("wr_data", writedata, exp_wr[0].d);
          void'(exp_wr.pop_front());
        end
      end
      if (memread) begin
        if (exp_fetch.size() == 0) chk("unexpected_memread", 32'd1, 32'd0);
        else begin
          chk("fetch_addr", {22'b0, address}, {22'b0, exp_fetch[0]});
          if (!rd_valid || rd_ready) void'(exp_fetch.pop_front());
        end
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) chk("unexpected_rd", 32'd1, 32'd0);
        else begin
          chk("rd_data", rd_data, exp_rd[0].d);
          chk("rd_last", {31'b0, rd_last}, {31'b0, exp_rd[0].last});
          void'(exp_rd.pop_front());
        end
      end
      if (prev_stall) begin
        chk("hold_valid", {31'b0, rd_valid}, 32'd1);
        chk("hold_data", rd_data, prev_data);
        chk("hold_last", {31'b0, rd_last}, {31'b0, prev_last});
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        chk("done_one_cycle", {31'b0, prev_done}, 32'd0);
      end
      prev_stall <= rd_valid && !rd_ready;
      prev_data  <= rd_data;
      prev_last  <= rd_last;
      prev_done  <= done;
    end
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_memread"}, {31'b0, memread}, 32'd0);
    chk({tag, "_memwrite"}, {31'b0, memwrite}, 32'd0);
    chk({tag, "_wr_ready"}, {31'b0, wr_ready}, 32'd0);
    chk({tag, "_rd_valid"}, {31'b0, rd_valid}, 32'd0);
    chk({tag, "_rd_last"}, {31'b0, rd_last}, 32'd0);
    chk({tag, "_address"}, {22'b0, address}, 32'd0);
    chk({tag, "_writedata"}, writedata, 32'd0);
    chk({tag, "_rd_data"}, rd_data, 32'd0);
  endtask

  // Write slots: each slot is one cycle, ws_vld=0 slots are gaps carrying junk data.
  logic          ws_vld [8];
  logic [DW-1:0] ws_dat [8];
  int            nslots;
  int            pulse_slot;
  logic          rp_pat [4];
  int            rp_n;

  task automatic do_write(input logic [AW-1:0] a, input int len);
    int k;
    logic [AW-1:0] wa;
    wexp_t w;
    k = 0;
    for (int s = 0; s < nslots; s++) begin
      if (ws_vld[s]) begin
        wa = a + AW'(k);
        w.a = wa;
        w.d = ws_dat[s];
        exp_wr.push_back(w);
        ref_mem[wa] = ws_dat[s];
        k++;
      end
    end
    cmd_write = 1'b1; cmd_addr = a; cmd_len = LW'(len); cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int s = 0; s < nslots; s++) begin
      wr_valid = ws_vld[s];
      wr_data = ws_dat[s];
      if (s == pulse_slot) begin
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
      end
      #1;
      chk("memwrite_follows_valid", {31'b0, memwrite}, {31'b0, wr_valid});
      chk("wr_ready_in_burst", {31'b0, wr_ready}, 32'd1);
      if (s == pulse_slot) chk("cmd_ready_mid_burst", {31'b0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
    wr_valid = 1'b0;
    wr_data = '0;
    chk("done_after_last_write", {31'b0, done}, 32'd1);
    chk("cmd_ready_in_done", {31'b0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    chk("cmd_ready_after_write", {31'b0, cmd_ready}, 32'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int len, input int expect_cyc);
    logic [AW-1:0] wa;
    rexp_t r;
    int cyc;
    int got;
    for (int i = 0; i <= len; i++) begin
      wa = a + AW'(i);
      exp_fetch.push_back(wa);
      r.d = ref_mem[wa];
      r.last = (i == len);
      exp_rd.push_back(r);
    end
    cmd_write = 1'b0; cmd_addr = a; cmd_len = LW'(len); cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 0;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      rd_ready = rp_pat[i % rp_n];
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        got = 1;
        break;
      end
    end
    chk("read_done_seen", got, 32'd1);
    if (expect_cyc > 0) chk("read_cycles", cyc, expect_cyc);
    rd_ready = 1'b0;
    @(posedge clk); #1;
    chk("cmd_ready_after_read", {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int saved_done;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    pulse_slot = -1;
    #12;
    chk_reset_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Four-word write at 0..3.
    ws_dat[0] = 32'hC00000F0; ws_dat[1] = 32'h00000F00;
    ws_dat[2] = 32'h0000F000; ws_dat[3] = 32'h000F0000;
    for (int s = 0; s < 4; s++) ws_vld[s] = 1'b1;
    nslots = 4; pulse_slot = -1;
    do_write(10'h000, 3);
    chk("mem0", env_mem[0], 32'hC00000F0);
    chk("mem1", env_mem[1], 32'h00000F00);
    chk("mem2", env_mem[2], 32'h0000F000);
    chk("mem3", env_mem[3], 32'h000F0000);

    // Streaming read back, then the same read under backpressure.
    rp_pat[0] = 1'b1; rp_n = 1;
    do_read(10'h000, 3, 5);
    rp_pat[0] = 1'b1; rp_pat[1] = 1'b0; rp_pat[2] = 1'b0; rp_pat[3] = 1'b1; rp_n = 4;
    do_read(10'h000, 3, -1);

    // Address wrap from the top of memory.
    ws_dat[0] = 32'hF0000F00; ws_dat[1] = 32'hC7030F00;
    ws_vld[0] = 1'b1; ws_vld[1] = 1'b1;
    nslots = 2; pulse_slot = -1;
    do_write(10'h3FF, 1);
    chk("wrap_mem_3ff", env_mem[1023], 32'hF0000F00);
    chk("wrap_mem_000", env_mem[0], 32'hC7030F00);
    rp_pat[0] = 1'b1; rp_n = 1;
    do_read(10'h3FF, 1, 3);

    // Gapped write with a stray command offered during the gap.
    ws_vld[0] = 1'b1; ws_dat[0] = 32'h11111111;
    ws_vld[1] = 1'b0; ws_dat[1] = 32'hDEADBEEF;
    ws_vld[2] = 1'b1; ws_dat[2] = 32'h22222222;
    nslots = 3; pulse_slot = 1;
    do_write(10'h010, 1);
    pulse_slot = -1;
    chk("gap_mem_010", env_mem[16], 32'h11111111);
    chk("gap_mem_011", env_mem[17], 32'h22222222);
    repeat (3) @(posedge clk);
    #1;
    chk("no_stray_burst", {31'b0, busy}, 32'd0);

    // Reset while the second word of a four-word read is held.
    rp_pat[0] = 1'b1; rp_n = 1;
    for (int i = 0; i <= 3; i++) begin
      rexp_t r;
      exp_fetch.push_back(AW'(i));
      r.d = ref_mem[i];
      r.last = (i == 3);
      exp_rd.push_back(r);
    end
    cmd_write = 1'b0; cmd_addr = '0; cmd_len = LW'(3); cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rd_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_rd_data", rd_data, 32'h00000F00);
    saved_done = done_cnt;
    rst_n = 1'b0;
    exp_fetch.delete();
    exp_rd.delete();
    #1;
    chk_reset_outs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      chk("post_reset_done", {31'b0, done}, 32'd0);
    end
    chk("no_done_after_reset", done_cnt, saved_done);
    rd_ready = 1'b0;

    chk("wr_queue_empty", exp_wr.size(), 32'd0);
    chk("rd_queue_empty", exp_rd.size(), 32'd0);
    chk("fetch_queue_empty", exp_fetch.size(), 32'd0);
    chk("total_done_pulses", done_cnt, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
